// File: rtl/sub_4bit_if.sv
// Operand/result bundle for the registered subtractor.
// The master side drives the operands; the slave side (the subtractor) returns results.
interface sub_4bit_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             zero;
  logic             out_valid;

  modport master (
    output in_valid, a, b, cin,
    input  sum, cout, overflow, zero, out_valid
  );

  modport slave (
    input  in_valid, a, b, cin,
    output sum, cout, overflow, zero, out_valid
  );
endinterface

// File: rtl/sub_4bit.sv
// Registered two's-complement subtractor: {cout,sum} = a + ~b + cin.
// cin=1 gives a-b (cout=1 means no borrow); cin=0 gives a-b-1 for borrow chaining.
// Also reports signed overflow and a zero result. One cycle of latency, no backpressure.
module sub_4bit #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  sub_4bit_if.slave  bus
);

  logic [WIDTH:0]   full_sum;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             overflow_d, overflow_q;
  logic             zero_d, zero_q;
  logic             out_valid_d, out_valid_q;

  // Signed overflow of a - b: operand signs differ and the result sign departs from the minuend.
  function automatic logic sub_overflow(input logic [WIDTH-1:0] op_a,
                                        input logic [WIDTH-1:0] op_b,
                                        input logic [WIDTH-1:0] res);
    return (op_a[WIDTH-1] != op_b[WIDTH-1]) && (res[WIDTH-1] != op_a[WIDTH-1]);
  endfunction

  // Next result: computed when an operation is accepted, otherwise the last result is held.
  always_comb begin
    full_sum    = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, bus.cin};
    sum_d       = sum_q;
    cout_d      = cout_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    if (bus.in_valid) begin
      sum_d       = full_sum[WIDTH-1:0];
      cout_d      = full_sum[WIDTH];
      overflow_d  = sub_overflow(bus.a, bus.b, full_sum[WIDTH-1:0]);
      zero_d      = (full_sum[WIDTH-1:0] == '0);
      out_valid_d = 1'b1;
    end
  end

  // Result register; reset clears everything and discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_sub_4bit.sv
// Scoreboard bench for sub_4bit: the driver pushes reference results computed with
// plain integer arithmetic; an independent monitor pops and compares on out_valid.
module tb_sub_4bit;
  localparam int W = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  bit   mon_run;
  exp_t exp_q[$];

  sub_4bit_if #(.WIDTH(W)) bus ();

  sub_4bit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: a - b - (1 - cin) evaluated as integers, then reduced mod 2^W.
  function automatic exp_t model(input int a, input int b, input int cin);
    exp_t e;
    int   diff;
    int   sa;
    int   sb;
    int   sdiff;
    diff  = a - b - (1 - cin);
    e.sum = W'((diff + (1 << W)) % (1 << W));
    e.cout = (diff >= 0);
    sa    = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb    = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    sdiff = sa - sb - (1 - cin);
    e.ovf = (sdiff > (1 << (W - 1)) - 1) || (sdiff < -(1 << (W - 1)));
    e.zero = (e.sum == 0);
    return e;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus, applied on the falling edge so it is stable at the rising edge.
  task automatic issue(input logic v, input int a, input int b, input logic c, input logic r);
    @(negedge clk);
    rst          = r;
    bus.in_valid = v;
    bus.a        = W'(a);
    bus.b        = W'(b);
    bus.cin      = c;
    if (v && !r) exp_q.push_back(model(a, b, int'(c)));
  endtask

  // Monitor: compares the DUT state just after every rising edge.
  initial begin
    exp_t hold;
    exp_t e;
    logic r_s;
    hold = '{sum: '0, cout: 1'b0, ovf: 1'b0, zero: 1'b0};
    wait (mon_run);
    forever begin
      @(posedge clk);
      r_s = rst;
      #1;
      if (r_s) begin
        exp_q.delete();
        hold = '{sum: '0, cout: 1'b0, ovf: 1'b0, zero: 1'b0};
        check("rst_out_valid", W'(bus.out_valid), W'(1'b0));
        check("rst_sum", bus.sum, '0);
        check("rst_flags", W'({bus.cout, bus.overflow, bus.zero}), W'(3'b000));
      end else if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: got out_valid=1, expected 0 at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("sum", bus.sum, e.sum);
          check("cout", W'(bus.cout), W'(e.cout));
          check("overflow", W'(bus.overflow), W'(e.ovf));
          check("zero", W'(bus.zero), W'(e.zero));
          hold = e;
        end
      end else begin
        if (exp_q.size() != 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL missing_valid: got out_valid=%b, expected 1 at %0t", bus.out_valid, $time);
          void'(exp_q.pop_front());
        end
        check("hold_sum", bus.sum, hold.sum);
        check("hold_flags", W'({bus.cout, bus.overflow, bus.zero}),
              W'({hold.cout, hold.ovf, hold.zero}));
      end
    end
  end

  // Driver: directed corner cases first, then randomized traffic with occasional reset.
  initial begin
    n_checks     = 0;
    n_fail       = 0;
    mon_run      = 1'b0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.cin      = 1'b0;
    @(negedge clk);
    mon_run = 1'b1;
    issue(1'b0, 0, 0, 1'b0, 1'b1);
    issue(1'b1, 4'b0110, 4'b1100, 1'b1, 1'b0);
    issue(1'b1, 4'b1110, 4'b1000, 1'b1, 1'b0);
    issue(1'b1, 4'b0111, 4'b1110, 1'b1, 1'b0);
    issue(1'b1, 4'b0010, 4'b1001, 1'b1, 1'b0);
    issue(1'b1, 4'b0101, 4'b0101, 1'b1, 1'b0);
    issue(1'b1, 4'b0000, 4'b0001, 1'b1, 1'b0);
    issue(1'b0, 4'b0011, 4'b0001, 1'b1, 1'b0);
    issue(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
    issue(1'b1, 4'b1010, 4'b1010, 1'b0, 1'b0);
    issue(1'b1, 4'b1000, 4'b0001, 1'b1, 1'b0);
    issue(1'b1, 4'b0111, 4'b1111, 1'b0, 1'b0);
    issue(1'b1, 4'b0101, 4'b0101, 1'b1, 1'b1);
    issue(1'b1, 4'b0101, 4'b0011, 1'b1, 1'b0);
    issue(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b1);
    issue(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      issue(1'b1 && ($urandom_range(0, 3) != 0),
            int'($urandom_range(0, (1 << W) - 1)),
            int'($urandom_range(0, (1 << W) - 1)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 29) == 0));
    end
    issue(1'b0, 0, 0, 1'b0, 1'b0);
    issue(1'b0, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending results, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
